// File: rtl/cnn_layer_accel_axil_pkg.sv
// Shared types and helpers for the layer-accel AXI4-Lite control port.
package cnn_layer_accel_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // Byte address to 32-bit word index; the two byte-lane bits are dropped.
  function automatic logic [31:0] word_idx(input logic [31:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_axil_slave_if.sv
// AXI4-Lite bus bundle for the accelerator S00_AXI control port.
interface cnn_layer_accel_axil_slave_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] S_AXI_AWADDR;
  logic [2:0]        S_AXI_AWPROT;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;
  logic [31:0]       S_AXI_WDATA;
  logic [3:0]        S_AXI_WSTRB;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;
  logic [ADDR_W-1:0] S_AXI_ARADDR;
  logic [2:0]        S_AXI_ARPROT;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [31:0]       S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

endinterface

// File: rtl/cnn_layer_accel_axil_regfile.sv
// Byte-strobed configuration register bank; one-hot write select, one-cycle
// update pulse per register aligned with the cycle the new value appears.
module cnn_layer_accel_axil_regfile #(
  parameter int NUM_REGS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REGS-1:0]      wr_sel,
  input  logic [31:0]              wr_data,
  input  logic [3:0]               wr_strb,
  output logic [NUM_REGS*32-1:0]   regs,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs     <= '0;
      wr_pulse <= '0;
    end else begin
      // Pulse follows the select even with an all-zero strobe.
      wr_pulse <= wr_sel;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_sel[k]) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) regs[32*k + 8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/cnn_layer_accel_axil_slave.sv
// AXI4-Lite responder: RW config registers plus one read-only status word.
//
// state  | meaning
// W_IDLE | collecting AW and W into holding regs; commits once both are present
// W_RESP | write committed, BVALID/BRESP held until BREADY
// R_IDLE | ARREADY high, waiting for a read address
// R_DATA | RVALID with registered RDATA/RRESP held until RREADY
module cnn_layer_accel_axil_slave
  import cnn_layer_accel_axil_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 32
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  cnn_layer_accel_axil_slave_if.slave  s_axi,
  output logic [NUM_REGS*DATA_W-1:0]   cfg_regs_o,
  output logic [NUM_REGS-1:0]          cfg_wr_pulse_o,
  input  logic [DATA_W-1:0]            status_i
);

  logic [1:0]        rst_sync;
  logic              rst_n;

  w_state_t          w_state, w_state_nxt;
  r_state_t          r_state, r_state_nxt;

  logic              aw_held, w_held;
  logic [ADDR_W-1:0] awaddr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [1:0]        bresp_q;

  logic              aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic              commit;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic [31:0]       wr_idx;
  logic              wr_ok;
  logic [NUM_REGS-1:0] wr_sel;

  logic [31:0]       rd_idx;
  logic [DATA_W-1:0] rd_data, rdata_q;
  logic [1:0]        rd_resp, rresp_q;

  logic              unused_prot;

  // Assert asynchronously, release two edges after ARESETN rises.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign unused_prot = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

  assign s_axi.S_AXI_AWREADY = (w_state == W_IDLE) && !aw_held;
  assign s_axi.S_AXI_WREADY  = (w_state == W_IDLE) && !w_held;
  assign s_axi.S_AXI_BVALID  = (w_state == W_RESP);
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = (r_state == R_IDLE);
  assign s_axi.S_AXI_RVALID  = (r_state == R_DATA);
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;

  assign aw_hs = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
  assign w_hs  = s_axi.S_AXI_WVALID  && s_axi.S_AXI_WREADY;
  assign b_hs  = s_axi.S_AXI_BVALID  && s_axi.S_AXI_BREADY;
  assign ar_hs = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
  assign r_hs  = s_axi.S_AXI_RVALID  && s_axi.S_AXI_RREADY;

  // Commit on the edge that completes the pair so BVALID trails the later
  // of the two handshakes by exactly one cycle.
  assign commit  = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_addr = aw_hs ? s_axi.S_AXI_AWADDR : awaddr_q;
  assign wr_data = w_hs  ? s_axi.S_AXI_WDATA  : wdata_q;
  assign wr_strb = w_hs  ? s_axi.S_AXI_WSTRB  : wstrb_q;
  assign wr_idx  = word_idx(32'(wr_addr));
  assign wr_ok   = wr_idx < 32'(NUM_REGS);

  always_comb begin
    wr_sel = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (commit && (wr_idx == 32'(k))) wr_sel[k] = 1'b1;
    end
  end

  cnn_layer_accel_axil_regfile #(
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk      (ACLK),
    .rst_n    (rst_n),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .wr_strb  (wr_strb),
    .regs     (cfg_regs_o),
    .wr_pulse (cfg_wr_pulse_o)
  );

  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (commit) w_state_nxt = W_RESP;
      W_RESP:  if (b_hs)   w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
    end else if (commit) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        awaddr_q <= s_axi.S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= s_axi.S_AXI_WDATA;
        wstrb_q <= s_axi.S_AXI_WSTRB;
      end
    end
  end

  assign rd_idx = word_idx(32'(s_axi.S_AXI_ARADDR));

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_SLVERR;
    if (rd_idx == 32'(NUM_REGS)) begin
      rd_data = status_i;
      rd_resp = RESP_OKAY;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (rd_idx == 32'(k)) begin
          rd_data = cfg_regs_o[k*DATA_W +: DATA_W];
          rd_resp = RESP_OKAY;
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (r_hs)  r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Snapshot taken at the AR edge, so a same-edge commit is not visible.
  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_data;
      rresp_q <= rd_resp;
    end
  end

endmodule
